qpu_exu_trigger: RTL and testbench
==================================

Name: qpu_exu_trigger

Overview:
- Timing/dispatch stage directly downstream of the execution-unit time/event queue.
- Owns the global QPU timeline counter; drives the trigger and the current time value back to the queue.
- Advances time only when the queue grants clock enable.
- Registers the events the queue releases into per-channel output ports for the AWG/measurement front ends, and flags a stalled timeline.

Parameters:
- TIME_WIDTH, 16, width of the timeline counter; matches the queue time width.
- EVENT_NUM, 4, total event channels (qubit-op plus measure).
- QI_EVENT_NUM, 3, qubit-op channels, occupying indices 0..QI_EVENT_NUM-1.
- QI_EVENT_WIDTH, 16, bits per qubit-op event.
- MEASURE_EVENT_WIDTH, 8, bits per measure event.
- EVENT_WIRE_WIDTH, QI_EVENT_NUM*QI_EVENT_WIDTH+(EVENT_NUM-QI_EVENT_NUM)*MEASURE_EVENT_WIDTH, packed event bus width.
- STALL_MAX, 255, consecutive no-advance cycles allowed while running before error.
- STALL_CNT_WIDTH, 8, stall counter width; must satisfy 2^STALL_CNT_WIDTH > STALL_MAX.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- run_start  in  1  single-cycle pulse; begin timeline.
- run_stop  in  1  single-cycle pulse; abort/finish timeline.
- tmr_clk_ena  in  1  queue's clock-enable grant (trigger_o_clk_ena).
- tmr_trigger  out  1  trigger to queue (queue i_trigger).
- tmr_value  out  TIME_WIDTH  current timeline value (queue trigger_o_clk).
- evq_i_valid  in  EVENT_NUM  per-channel event valid from queue.
- evq_i_data  in  EVENT_WIRE_WIDTH  packed event data from queue.
- chan_o_valid  out  EVENT_NUM  registered per-channel event strobe.
- chan_o_data  out  EVENT_WIRE_WIDTH  registered packed event data.
- tmr_wrap  out  1  one-cycle pulse when timeline wraps to 0.
- stall_err  out  1  sticky stall-timeout flag.
- busy  out  1  high in RUN or ERR.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs, timer, stall counter and channel registers = 0. Applies mid-run with no drain.
- States and transitions:
  - IDLE: run_start -> RUN.
  - RUN: run_stop -> IDLE; stall counter reaching STALL_MAX with tmr_clk_ena=0 -> ERR.
  - ERR: run_stop -> IDLE; run_start ignored.
  - run_stop has priority over run_start and over the error transition in the same cycle. run_start in RUN is ignored.
- tmr_trigger = (state==RUN), registered. It is 1 on the cycle after run_start is sampled.
- Timer:
  - Registered; tmr_value = timer_r.
  - Entering RUN: timer_r holds 0 (cleared on every return to IDLE), so queue head time 0 matches on the first RUN cycle.
  - In RUN with tmr_clk_ena=1: timer_r <= timer_r+1, modulo 2^TIME_WIDTH.
  - All-ones -> 0 wrap: tmr_wrap=1 in the cycle timer_r reads 0.
  - tmr_clk_ena=0 in RUN: timer holds.
  - IDLE: timer_r=0. ERR: timer frozen.
- Stall counter:
  - Cleared on any cycle with tmr_clk_ena=1 or outside RUN.
  - Increments on each RUN cycle with tmr_clk_ena=0.
  - When the counter equals STALL_MAX-1 and tmr_clk_ena=0: next state ERR, stall_err<=1.
  - stall_err clears only on run_stop or reset.
- Event capture, latency 1:
  - When tmr_trigger=1 and evq_i_valid[k]=1: chan_o_valid[k]<=1 and that channel's slice of chan_o_data <= the evq_i_data slice.
  - Otherwise chan_o_valid[k]<=0 and the slice holds its last value.
  - Channels are independent; multiple channels may fire in one cycle.
  - Valid events outside RUN are dropped, with no output.
- Slice layout:
  - Qubit-op channel k<QI_EVENT_NUM: [k*QI_EVENT_WIDTH +: QI_EVENT_WIDTH].
  - Measure channel m=k-QI_EVENT_NUM: [QI_EVENT_NUM*QI_EVENT_WIDTH + m*MEASURE_EVENT_WIDTH +: MEASURE_EVENT_WIDTH].
- busy = (state!=IDLE).

Decomposition:
- Shared package/defines file, alongside existing QPU defines:
  - Widths: TIME_WIDTH, EVENT_NUM, QI_EVENT_NUM, QI_EVENT_WIDTH, MEASURE_EVENT_WIDTH, EVENT_WIRE_WIDTH.
  - State encoding constants: IDLE=2'b00, RUN=2'b01, ERR=2'b10.
- Flops use the existing general dff-with-load/reset library cells.
- One natural sub-module: qpu_trigger_chan_reg. It is the per-channel capture register (valid strobe plus data slice, width parameter), instantiated in a generate loop per channel.

Test Plan:
- Reset then run_start at cycle 5, tmr_clk_ena=1 constantly -> tmr_trigger=1 from cycle 6; tmr_value=0 at cycle 6, 1 at cycle 7, 10 at cycle 16.
- In RUN at timer=0xFFFE with ena=1 -> next 0xFFFF, then 0x0000 with tmr_wrap=1 for exactly that cycle.
- evq_i_valid=4'b1001, qubit-op ch0 data 0xA5A5, measure ch3 data 0x3C -> next cycle chan_o_valid=4'b1001 with slices 0xA5A5 and 0x3C; the following cycle chan_o_valid=0 and data holds.
- tmr_clk_ena=0 for 255 cycles in RUN -> ERR: stall_err=1, tmr_trigger=0, timer frozen. 254 stalled cycles then ena=1 -> no error, counter cleared.
- run_start and run_stop in the same cycle from RUN -> IDLE with timer=0. run_stop in ERR -> IDLE with stall_err=0.
- rst_n asserted mid-run with events in flight -> all outputs 0 immediately (async). Events presented in IDLE -> no chan_o_valid.

Source files
------------

// File: rtl/qpu_exu_trigger_pkg.sv
// Shared widths, state encoding and channel slice helpers for the QPU
// execution-unit trigger stage.
package qpu_exu_trigger_pkg;

  localparam int TIME_WIDTH          = 16;
  localparam int EVENT_NUM           = 4;
  localparam int QI_EVENT_NUM        = 3;
  localparam int QI_EVENT_WIDTH      = 16;
  localparam int MEASURE_EVENT_WIDTH = 8;
  localparam int EVENT_WIRE_WIDTH    = QI_EVENT_NUM * QI_EVENT_WIDTH
                                     + (EVENT_NUM - QI_EVENT_NUM) * MEASURE_EVENT_WIDTH;
  localparam int STALL_MAX           = 255;
  localparam int STALL_CNT_WIDTH     = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;

  // Qubit-op channels are packed first, measure channels follow.
  function automatic int chan_width(input int k, input int qi_num,
                                    input int qi_w, input int meas_w);
    return (k < qi_num) ? qi_w : meas_w;
  endfunction

  function automatic int chan_lsb(input int k, input int qi_num,
                                  input int qi_w, input int meas_w);
    return (k < qi_num) ? k * qi_w : qi_num * qi_w + (k - qi_num) * meas_w;
  endfunction

endpackage

// File: rtl/qpu_trigger_chan_reg.sv
// Per-channel capture register: one-cycle valid strobe plus a data slice
// that holds its last captured value between events.
module qpu_trigger_chan_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // NOTE: the data slice is a handful of output flops, not a memory, and the
  // front ends expect zeros after reset, so it is reset along with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= capture_i;
      if (capture_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/qpu_exu_trigger.sv
// Timing/dispatch stage behind the EXU time/event queue: owns the timeline
// counter, triggers the queue, registers released events per channel.
module qpu_exu_trigger
  import qpu_exu_trigger_pkg::*;
#(
  parameter int TIME_WIDTH_P          = TIME_WIDTH,
  parameter int EVENT_NUM_P           = EVENT_NUM,
  parameter int QI_EVENT_NUM_P        = QI_EVENT_NUM,
  parameter int QI_EVENT_WIDTH_P      = QI_EVENT_WIDTH,
  parameter int MEASURE_EVENT_WIDTH_P = MEASURE_EVENT_WIDTH,
  parameter int EVENT_WIRE_WIDTH_P    = QI_EVENT_NUM_P * QI_EVENT_WIDTH_P
                                      + (EVENT_NUM_P - QI_EVENT_NUM_P) * MEASURE_EVENT_WIDTH_P,
  parameter int STALL_MAX_P           = STALL_MAX,
  parameter int STALL_CNT_WIDTH_P     = STALL_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run_start,
  input  logic                          run_stop,
  input  logic                          tmr_clk_ena,
  output logic                          tmr_trigger,
  output logic [TIME_WIDTH_P-1:0]       tmr_value,
  input  logic [EVENT_NUM_P-1:0]        evq_i_valid,
  input  logic [EVENT_WIRE_WIDTH_P-1:0] evq_i_data,
  output logic [EVENT_NUM_P-1:0]        chan_o_valid,
  output logic [EVENT_WIRE_WIDTH_P-1:0] chan_o_data,
  output logic                          tmr_wrap,
  output logic                          stall_err,
  output logic                          busy
);

  logic [1:0]                   state_q, state_d;
  logic [TIME_WIDTH_P-1:0]      timer_q, timer_d;
  logic [STALL_CNT_WIDTH_P-1:0] stall_q, stall_d;
  logic                         stall_err_q, stall_err_d;
  logic                         wrap_q, wrap_d;
  logic                         running;
  logic                         advance;

  assign running = (state_q == ST_RUN);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    stall_err_d = stall_err_q;
    case (state_q)
      ST_IDLE: if (!run_stop && run_start) state_d = ST_RUN;
      ST_RUN: begin
        if (run_stop) begin
          state_d = ST_IDLE;
        end else if (!tmr_clk_ena &&
                     stall_q == STALL_CNT_WIDTH_P'(STALL_MAX_P - 1)) begin
          state_d     = ST_ERR;
          stall_err_d = 1'b1;
        end
      end
      ST_ERR:  if (run_stop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (run_stop) stall_err_d = 1'b0;
  end

  // Time only moves while staying in RUN; the error exit needs ena low anyway.
  assign advance = running && !run_stop && tmr_clk_ena;

  always_comb begin
    timer_d = timer_q;
    if (state_d == ST_IDLE)  timer_d = '0;
    else if (advance)        timer_d = timer_q + TIME_WIDTH_P'(1);
    wrap_d  = advance && (timer_q == '1);
    stall_d = (running && !tmr_clk_ena) ? stall_q + STALL_CNT_WIDTH_P'(1) : '0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      stall_q     <= '0;
      stall_err_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_q     <= stall_d;
      stall_err_q <= stall_err_d;
      wrap_q      <= wrap_d;
    end
  end

  assign tmr_trigger = running;
  assign tmr_value   = timer_q;
  assign tmr_wrap    = wrap_q;
  assign stall_err   = stall_err_q;
  assign busy        = (state_q != ST_IDLE);

  for (genvar k = 0; k < EVENT_NUM_P; k++) begin : g_chan
    localparam int W   = chan_width(k, QI_EVENT_NUM_P, QI_EVENT_WIDTH_P,
                                    MEASURE_EVENT_WIDTH_P);
    localparam int LSB = chan_lsb(k, QI_EVENT_NUM_P, QI_EVENT_WIDTH_P,
                                  MEASURE_EVENT_WIDTH_P);

    qpu_trigger_chan_reg #(
      .WIDTH (W)
    ) u_chan_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture_i (running && evq_i_valid[k]),
      .data_i    (evq_i_data[LSB +: W]),
      .valid_o   (chan_o_valid[k]),
      .data_o    (chan_o_data[LSB +: W])
    );
  end

endmodule

// File: tb/tb_qpu_exu_trigger.sv
// Directed self-checking bench for qpu_exu_trigger: start timing, event
// capture, wrap, stall boundary, error recovery and async reset.
module tb_qpu_exu_trigger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_start, run_stop, tmr_clk_ena;
  logic        tmr_trigger, tmr_wrap, stall_err, busy;
  logic [15:0] tmr_value;
  logic [3:0]  evq_i_valid, chan_o_valid;
  logic [55:0] evq_i_data, chan_o_data;

  int checks   = 0;
  int failures = 0;

  qpu_exu_trigger dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_start    (run_start),
    .run_stop     (run_stop),
    .tmr_clk_ena  (tmr_clk_ena),
    .tmr_trigger  (tmr_trigger),
    .tmr_value    (tmr_value),
    .evq_i_valid  (evq_i_valid),
    .evq_i_data   (evq_i_data),
    .chan_o_valid (chan_o_valid),
    .chan_o_data  (chan_o_data),
    .tmr_wrap     (tmr_wrap),
    .stall_err    (stall_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run_start = 1'b0; run_stop = 1'b0; tmr_clk_ena = 1'b0;
    evq_i_valid = '0; evq_i_data = '0;
    repeat (3) step();
    check("rst_trigger", tmr_trigger, 1'b0);
    check("rst_value",   tmr_value,   16'h0);
    check("rst_busy",    busy,        1'b0);
    check("rst_stall",   stall_err,   1'b0);
    check("rst_wrap",    tmr_wrap,    1'b0);
    check("rst_cvalid",  chan_o_valid, 4'h0);
    check("rst_cdata",   chan_o_data,  56'h0);

    // Start: trigger and time 0 on the first RUN cycle.
    rst_n = 1'b1; run_start = 1'b1; tmr_clk_ena = 1'b1;
    step();
    run_start = 1'b0;
    check("start_trigger", tmr_trigger, 1'b1);
    check("start_busy",    busy,        1'b1);
    check("start_value0",  tmr_value,   16'd0);
    step();
    check("start_value1",  tmr_value,   16'd1);
    repeat (9) step();
    check("start_value10", tmr_value,   16'd10);

    // Event capture: ch0 and ch3 only.
    evq_i_valid = 4'b1001;
    evq_i_data  = {8'h3C, 16'h2222, 16'h1111, 16'hA5A5};
    step();
    check("ev1_valid", chan_o_valid, 4'b1001);
    check("ev1_data",  chan_o_data,  56'h3C_0000_0000_A5A5);
    evq_i_valid = 4'b0000;
    evq_i_data  = {8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    step();
    check("ev1_valid_drop", chan_o_valid, 4'b0000);
    check("ev1_data_hold",  chan_o_data,  56'h3C_0000_0000_A5A5);
    evq_i_valid = 4'b0110;
    evq_i_data  = {8'hFF, 16'h1234, 16'hBEEF, 16'hFFFF};
    step();
    check("ev2_valid", chan_o_valid, 4'b0110);
    check("ev2_data",  chan_o_data,  56'h3C_1234_BEEF_A5A5);
    evq_i_valid = 4'b0000;
    step();
    check("ev2_value", tmr_value, 16'd14);

    // Wrap: 14 -> 0xFFFE, then 0xFFFF, then 0 with a one-cycle wrap pulse.
    repeat (65534 - 14) step();
    check("wrap_fffe",   tmr_value, 16'hFFFE);
    check("wrap_fffe_w", tmr_wrap,  1'b0);
    step();
    check("wrap_ffff",   tmr_value, 16'hFFFF);
    check("wrap_ffff_w", tmr_wrap,  1'b0);
    step();
    check("wrap_zero",   tmr_value, 16'h0000);
    check("wrap_zero_w", tmr_wrap,  1'b1);
    step();
    check("wrap_one",    tmr_value, 16'h0001);
    check("wrap_one_w",  tmr_wrap,  1'b0);

    // 254 stalled cycles then a grant: no error, timer held then advances.
    tmr_clk_ena = 1'b0;
    repeat (254) step();
    check("stall254_err",  stall_err,   1'b0);
    check("stall254_trig", tmr_trigger, 1'b1);
    check("stall254_hold", tmr_value,   16'h0001);
    tmr_clk_ena = 1'b1;
    step();
    check("stall254_adv",  tmr_value,   16'h0002);
    check("stall254_err2", stall_err,   1'b0);

    // 255 stalled cycles: error on the 255th.
    tmr_clk_ena = 1'b0;
    repeat (254) step();
    check("stall255_pre_err",  stall_err,   1'b0);
    check("stall255_pre_trig", tmr_trigger, 1'b1);
    step();
    check("stall255_err",   stall_err,   1'b1);
    check("stall255_trig",  tmr_trigger, 1'b0);
    check("stall255_busy",  busy,        1'b1);
    check("stall255_value", tmr_value,   16'h0002);

    // ERR: timer frozen even with ena, events dropped, run_start ignored.
    tmr_clk_ena = 1'b1;
    evq_i_valid = 4'b1111;
    evq_i_data  = {8'h11, 16'h2222, 16'h3333, 16'h4444};
    step();
    check("err_value",  tmr_value,    16'h0002);
    check("err_cvalid", chan_o_valid, 4'b0000);
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    check("err_start_busy", busy,      1'b1);
    check("err_start_err",  stall_err, 1'b1);
    run_stop = 1'b1;
    step();
    run_stop = 1'b0;
    check("err_stop_busy",  busy,      1'b0);
    check("err_stop_err",   stall_err, 1'b0);
    check("err_stop_value", tmr_value, 16'h0000);

    // IDLE: presented events produce nothing, data holds.
    step();
    check("idle_cvalid", chan_o_valid, 4'b0000);
    check("idle_cdata",  chan_o_data,  56'h3C_1234_BEEF_A5A5);
    evq_i_valid = 4'b0000;

    // run_start and run_stop together in RUN: stop wins, timer cleared.
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    repeat (3) step();
    check("ss_value3", tmr_value, 16'd3);
    run_start = 1'b1; run_stop = 1'b1;
    step();
    check("ss_busy",    busy,        1'b0);
    check("ss_trigger", tmr_trigger, 1'b0);
    check("ss_value",   tmr_value,   16'd0);
    // Same pair from IDLE: stop still wins.
    step();
    run_start = 1'b0; run_stop = 1'b0;
    check("ss_idle_busy", busy, 1'b0);

    // Async reset mid-run with events in flight.
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    evq_i_valid = 4'b1111;
    evq_i_data  = {8'h5A, 16'h6666, 16'h7777, 16'h8888};
    step();
    check("mid_cvalid", chan_o_valid, 4'b1111);
    check("mid_value",  tmr_value,    16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trigger", tmr_trigger,  1'b0);
    check("arst_busy",    busy,         1'b0);
    check("arst_value",   tmr_value,    16'h0);
    check("arst_cvalid",  chan_o_valid, 4'h0);
    check("arst_cdata",   chan_o_data,  56'h0);
    check("arst_stall",   stall_err,    1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_cvalid", chan_o_valid, 4'h0);
    check("post_rst_busy",   busy,         1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
